// File: rtl/mem_stage.sv
// Memory stage of the pipelined ARM core: E->M register, data-memory
// req/ack handshake with timeout abort, M->W register, operand forwarding
// selects and pipeline stall generation.
module mem_stage #(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic [3:0]    RdE,
  input  logic [3:0]    RA1E,
  input  logic [3:0]    RA2E,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] ResultW,
  output logic [3:0]    RdW,
  output logic          RegWriteW,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          stall,
  output logic          bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_abort, w_abort_n;
  logic            r_bus_err, w_bus_err_n;
  logic            w_busy, w_req, w_cap;
  logic [DW-1:0]   r_rdata;

  // M pipeline register
  logic            r_regwrite_m, r_memtoreg_m, r_memwrite_m;
  logic [3:0]      r_rd_m;
  logic [DW-1:0]   r_alu_m, r_wdata_m;

  // W pipeline register
  logic            r_regwrite_w;
  logic [3:0]      r_rd_w;
  logic [DW-1:0]   r_result_w;

  logic            w_memop, w_loaduse;

  assign w_memop   = r_memtoreg_m | r_memwrite_m;
  assign w_loaduse = r_memtoreg_m & r_regwrite_m &
                     ((r_rd_m == RA1E) | (r_rd_m == RA2E));

  // FSM state, timeout counter, abort marker and sticky bus error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_abort   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_abort   <= w_abort_n;
      r_bus_err <= w_bus_err_n;
    end
  end

  // Next-state and handshake decode; DONE always retires the access so an
  // IDLE cycle with a memop in M is always a fresh request.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_abort_n   = r_abort;
    w_bus_err_n = r_bus_err;
    w_busy      = 1'b0;
    w_req       = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_busy = 1'b1;
          w_req  = 1'b1;
          if (mem_ack) begin
            w_cap     = 1'b1;
            w_abort_n = 1'b0;
            w_state_n = S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_abort_n   = 1'b1;
            w_bus_err_n = 1'b1;
            w_state_n   = S_DONE;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      S_DONE: begin
        w_cnt_n   = '0;
        w_abort_n = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Load data captured in the ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdata <= '0;
    else if (w_cap) r_rdata <= mem_rdata;
  end

  // E->M register: hold while busy, bubble on load-use, else advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_rd_m       <= '0;
      r_alu_m      <= '0;
      r_wdata_m    <= '0;
    end else if (w_busy) begin
      r_regwrite_m <= r_regwrite_m;
    end else if (w_loaduse) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
    end else begin
      r_regwrite_m <= RegWriteE;
      r_memtoreg_m <= MemtoRegE;
      r_memwrite_m <= MemWriteE;
      r_rd_m       <= RdE;
      r_alu_m      <= ALUResultE;
      r_wdata_m    <= WriteDataE;
    end
  end

  // M->W register: bubble while M is held, suppress write of aborted loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite_w <= 1'b0;
      r_rd_w       <= '0;
      r_result_w   <= '0;
    end else if (w_busy) begin
      r_regwrite_w <= 1'b0;
    end else begin
      r_regwrite_w <= r_regwrite_m & ~r_abort;
      r_rd_w       <= r_rd_m;
      r_result_w   <= r_memtoreg_m ? r_rdata : r_alu_m;
    end
  end

  // Operand forwarding selects, M match has priority over W
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (r_regwrite_m & ~r_memtoreg_m & (r_rd_m == RA1E))  forwardAE = 2'b10;
    else if (r_regwrite_w & (r_rd_w == RA1E))             forwardAE = 2'b01;
    if (r_regwrite_m & ~r_memtoreg_m & (r_rd_m == RA2E))  forwardBE = 2'b10;
    else if (r_regwrite_w & (r_rd_w == RA2E))             forwardBE = 2'b01;
  end

  assign mem_req    = w_req;
  assign mem_we     = r_memwrite_m;
  assign mem_addr   = r_alu_m;
  assign mem_wdata  = r_wdata_m;
  assign ALUResultM = r_alu_m;
  assign ResultW    = r_result_w;
  assign RdW        = r_rd_w;
  assign RegWriteW  = r_regwrite_w;
  assign stall      = w_busy | w_loaduse;
  assign bus_err    = r_bus_err;

endmodule
